// File: rtl/muldiv_unit_pkg.sv
// Shared op encoding (also driven by the decoder) and FSM state constants
// for the multiply/divide unit.
package MulDivOp;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5,
        NONE  = 3'd6
    } MulDivOp_t;

    typedef logic [1:0] MulDivState_t;
    localparam MulDivState_t IDLE = 2'd0;
    localparam MulDivState_t RUN  = 2'd1;
    localparam MulDivState_t FIX  = 2'd2;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring radix-2 divide step on a remainder:quotient pair.
module muldiv_divstep (
    input  logic [63:0] rq_i,
    input  logic [31:0] divisor_i,
    output logic [63:0] rq_o
);
    logic [32:0] rem_sh;
    logic [31:0] diff;
    logic        ge;

    // The shifted remainder can briefly need 33 bits before the subtract.
    assign rem_sh = rq_i[63:31];
    assign ge     = rem_sh >= {1'b0, divisor_i};
    assign diff   = rem_sh[31:0] - divisor_i;
    assign rq_o   = ge ? {diff, rq_i[30:0], 1'b1} : {rem_sh[31:0], rq_i[30:0], 1'b0};

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO. Define MULDIV_FAST_MULT_EN for a
// single-cycle multiplier path; division always iterates.
module muldiv_unit
    import MulDivOp::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  MulDivOp_t   op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hiloRead,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    MulDivState_t state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [63:0]  acc_q, acc_d;
    logic [31:0]  dvsr_q, dvsr_d;
    logic         is_div_q, is_div_d;
    logic         neg_q, neg_d;
    logic         negr_q, negr_d;
    logic [31:0]  hi_q, hi_d, lo_q, lo_d;
    logic         done_q, done_d;

    logic         op_signed, op_mul, op_div;
    logic [32:0]  madd;
    logic [63:0]  mul_nxt, div_nxt;

    assign op_signed = (op == MULT) || (op == DIV);
    assign op_mul    = (op == MULT) || (op == MULTU);
    assign op_div    = (op == DIV)  || (op == DIVU);

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign madd    = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? dvsr_q : 32'h0};
    assign mul_nxt = {madd, acc_q[31:1]};

    muldiv_divstep u_divstep (
        .rq_i      (acc_q),
        .divisor_i (dvsr_q),
        .rq_o      (div_nxt)
    );

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] ax, bx, fast_prod;
    // Low 64 bits of the sign-extended product are exact for both forms.
    assign ax        = {{32{op_signed & a[31]}}, a};
    assign bx        = {{32{op_signed & b[31]}}, b};
    assign fast_prod = ax * bx;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvsr_d   = dvsr_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (op_mul || op_div)) begin
                    is_div_d = op_div;
                    cnt_d    = 5'd0;
                    state_d  = RUN;
                    if (op_div && b == 32'h0) begin
                        // Divisor zero: raw dividend falls out as remainder, quotient all ones.
                        acc_d  = {32'h0, a};
                        dvsr_d = 32'h0;
                        neg_d  = 1'b0;
                        negr_d = 1'b0;
                    end else begin
                        acc_d  = {32'h0, magnitude(a, op_signed)};
                        dvsr_d = magnitude(b, op_signed);
                        neg_d  = op_signed & (a[31] ^ b[31]);
                        negr_d = op_signed & a[31];
                    end
`ifdef MULDIV_FAST_MULT_EN
                    if (op_mul) begin
                        acc_d   = fast_prod;
                        neg_d   = 1'b0;
                        state_d = FIX;
                    end
`endif
                end else if (start && op == MTHI) begin
                    hi_d = a;
                end else if (start && op == MTLO) begin
                    lo_d = a;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 5'd1;
                acc_d = is_div_q ? div_nxt : mul_nxt;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q  ? -acc_q[31:0]  : acc_q[31:0];
                    hi_d = negr_q ? -acc_q[63:32] : acc_q[63:32];
                end else begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'h0;
            dvsr_q   <= 32'h0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvsr_q   <= dvsr_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy & (start | hiloRead);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic model of HI/LO.
module tb_muldiv_unit;
    import MulDivOp::*;

    logic        clk, rst, start, flush, hiloRead;
    MulDivOp_t   op;
    logic [31:0] a, b;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    logic [31:0] hi_m, lo_m;
    int          n_chk, n_fail;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hiloRead(hiloRead), .busy(busy), .stall(stall),
        .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input MulDivOp_t o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        int          sq, sr;
        case (o)
            MULT:  begin p = longint'($signed(x)) * longint'($signed(y)); {hi_m, lo_m} = p; end
            MULTU: begin p = {32'h0, x} * {32'h0, y}; {hi_m, lo_m} = p; end
            DIV: begin
                if (y == 32'h0) begin lo_m = 32'hFFFFFFFF; hi_m = x; end
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin lo_m = 32'h80000000; hi_m = 32'h0; end
                else begin
                    sq = $signed(x) / $signed(y);
                    sr = $signed(x) % $signed(y);
                    lo_m = sq; hi_m = sr;
                end
            end
            DIVU: begin
                if (y == 32'h0) begin lo_m = 32'hFFFFFFFF; hi_m = x; end
                else begin lo_m = x / y; hi_m = x % y; end
            end
            MTHI: hi_m = x;
            MTLO: lo_m = x;
            default: ;
        endcase
    endtask

    function automatic int exp_lat(input MulDivOp_t o);
`ifdef MULDIV_FAST_MULT_EN
        if (o == MULT || o == MULTU) return 1;
`endif
        return 33;
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 100);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    // Issues one op; returns in the cycle done is high so the next op can issue back-to-back.
    task automatic do_op(input MulDivOp_t o, input logic [31:0] x, input logic [31:0] y);
        int   n;
        logic iter;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = NONE;
        chk("done_after_issue", done, 0);
        iter = o inside {MULT, MULTU, DIV, DIVU};
        model(o, x, y);
        if (iter) begin
            chk("busy_after_issue", busy, 1);
            wait_done(n);
            chk("latency", n, exp_lat(o));
        end else begin
            chk("busy_mt", busy, 0);
        end
        chk("hi", hi, hi_m);
        chk("lo", lo, lo_m);
        if (iter) chk("busy_at_done", busy, 0);
    endtask

    initial begin
        int          n, dcount;
        logic [2:0]  k;
        logic [31:0] x, y;
        MulDivOp_t   first_op;
        n_chk = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; flush = 1'b0; hiloRead = 1'b0;
        op = NONE; a = 32'h0; b = 32'h0;
        hi_m = 32'h0; lo_m = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(MULT, 32'hFFFFFFFE, 32'd3);
        chk("plan_mult_hi", hi, 32'hFFFFFFFF);
        chk("plan_mult_lo", lo, 32'hFFFFFFFA);
        @(posedge clk); #1;
        chk("done_single_pulse", done, 0);
        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("plan_multu_lo", lo, 32'h00000001);
        do_op(DIV, 32'hFFFFFFF9, 32'd2);
        chk("plan_div_lo", lo, 32'hFFFFFFFD);
        chk("plan_div_hi", hi, 32'hFFFFFFFF);
        do_op(DIVU, 32'd7, 32'd0);
        chk("plan_divu0_lo", lo, 32'hFFFFFFFF);
        chk("plan_divu0_hi", hi, 32'd7);
        do_op(DIV, 32'h80000000, 32'hFFFFFFFF);
        do_op(DIV, 32'h80000000, 32'h0);

        // Stall while busy; the re-issued start must be ignored.
`ifdef MULDIV_FAST_MULT_EN
        first_op = DIV;
`else
        first_op = MULT;
`endif
        op = first_op; a = 32'h00012345; b = 32'hFFFF0003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = NONE;
        model(first_op, 32'h00012345, 32'hFFFF0003);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7; hiloRead = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_busy", stall, 1);
            @(posedge clk); #1;
        end
        start = 1'b0; op = NONE;
        #1 chk("stall_hiloread_only", stall, 1);
        hiloRead = 1'b0;
        #1 chk("stall_no_req", stall, 0);
        wait_done(n);
        chk("stall_hi", hi, hi_m);
        chk("stall_lo", lo, lo_m);
        @(posedge clk); #1;
        chk("second_start_dropped", busy, 0);

        // Flush mid-divide preserves HI/LO and suppresses done.
        do_op(MTHI, 32'h12345678, 32'h0);
        op = DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = NONE;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_hi", hi, 32'h12345678);
        chk("flush_lo", lo, lo_m);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("flush_no_done", dcount, 0);

        // Flush beats a same-cycle start.
        flush = 1'b1; start = 1'b1; op = MTLO; a = 32'hDEADBEEF;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0; op = NONE;
        chk("flush_beats_start", lo, lo_m);
        chk("flush_beats_busy", busy, 0);

        // Async reset mid-RUN clears outputs without a clock edge.
        op = MULTU; a = 32'hFFFF1234; b = 32'h00ABCDEF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = NONE;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_hi", hi, 0);
        chk("async_rst_lo", lo, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        hi_m = 32'h0; lo_m = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 50; i++) begin
            k = 3'($urandom_range(0, 6));
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: begin
                    x = $urandom_range(0, 20); y = $urandom_range(1, 5);
                    if ($urandom_range(0, 1) == 1) x = -x;
                    if ($urandom_range(0, 1) == 1) y = -y;
                end
                default: ;
            endcase
            do_op(MulDivOp_t'(k), x, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
